// File: rtl/seq_det_pkg.sv
// seq_det_pkg: state encoding and sync-pattern defaults shared by the serial transmitter and detectors
package seq_det_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SYNC = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;
  localparam logic [1:0] ST_GAP  = 2'b11;
  localparam int DEF_SYNC_W = 4;
  localparam logic [3:0] DEF_SYNC_PAT = 4'b1011;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SYNC = ST_SYNC,
    S_DATA = ST_DATA,
    S_GAP  = ST_GAP
  } state_e;
  function automatic int max3(int a, int b, int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: parallel-in/serial-out shift register, MSB first
module piso_shreg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb,
  output logic         msb_nxt
);
  logic [W-1:0] sr_q, sr_d;
  // load wins over shift; otherwise hold
  always_comb sr_d = load ? din : shift ? sr_q << 1 : sr_q;
  // active-low synchronous clear
  always_ff @(posedge clk) sr_q <= !rst ? '0 : sr_d;
  assign msb = sr_q[W-1];
  assign msb_nxt = sr_q[W-2];
endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: sends sync pattern then payload MSB first, followed by a zero gap
import seq_det_pkg::*;
module serial_pattern_tx #(
  parameter int DATA_W = 8,
  parameter int SYNC_W = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(DEF_SYNC_PAT),
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              serout,
  output logic              frame,
  output logic              done,
  output logic [1:0]        ps,
  output logic [1:0]        ns
);
  localparam int W = SYNC_W + DATA_W;
  localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_CYC)) + 1;
  state_e ps_q, ns_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic serout_q, serout_d, frame_q, frame_d, done_q, done_d;
  logic load, shift, sr_msb, sr_nxt;
  assign in_ready = ps_q == S_IDLE;
  assign load = in_valid && in_ready;
  assign shift = ps_q == S_SYNC || ps_q == S_DATA;
  piso_shreg #(.W(W)) u_shreg (
    .clk(clk), .rst(rst), .load(load), .shift(shift),
    .din({SYNC_PAT, in_data}), .msb(sr_msb), .msb_nxt(sr_nxt)
  );
  // next state, per-state bit counter and the registered-output next values
  always_comb begin
    unique case (ps_q)
      S_IDLE:  ns_d = load ? S_SYNC : S_IDLE;
      S_SYNC:  ns_d = cnt_q == CNT_W'(SYNC_W - 1) ? S_DATA : S_SYNC;
      S_DATA:  ns_d = cnt_q == CNT_W'(DATA_W - 1) ? S_GAP : S_DATA;
      default: ns_d = cnt_q == CNT_W'(GAP_CYC - 1) ? S_IDLE : S_GAP;
    endcase
    cnt_d = (ns_d != ps_q || ps_q == S_IDLE) ? '0 : cnt_q + 1'b1;
    frame_d = ns_d == S_SYNC || ns_d == S_DATA;
    done_d = ps_q == S_DATA && ns_d == S_GAP;
    serout_d = frame_d & (load ? SYNC_PAT[SYNC_W-1] : shift ? sr_nxt : sr_msb);
  end
  // FSM and registered outputs; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      ps_q <= S_IDLE;
      cnt_q <= '0;
      serout_q <= 1'b0;
      frame_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ps_q <= ns_d;
      cnt_q <= cnt_d;
      serout_q <= serout_d;
      frame_q <= frame_d;
      done_q <= done_d;
    end
  end
  assign ps = ps_q;
  assign ns = ns_d;
  assign serout = serout_q;
  assign frame = frame_q;
  assign done = done_q;
endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial frame transmitter that feeds the team's serial sequence detectors. It accepts a parallel word over a valid/ready handshake and emits a fixed sync pattern followed by the word on `serout`, MSB first. It ends each frame with a zero-filled inter-frame gap. It is the stimulus/source end of the single-bit `serin` path and also serves as the loopback driver in detector benches.

## Interface
- `DATA_W`, default 8: payload width in bits (≥1).
- `SYNC_W`, default 4: sync pattern width in bits (≥1).
- `SYNC_PAT`, default 4'b1011: sync pattern, sent MSB first.
- `GAP_CYC`, default 2: idle-zero cycles after each frame (≥1).
- `clk` input, 1 bit: single clock, all logic on the rising edge.
- `rst` input, 1 bit: synchronous, active-low reset.
- `in_valid` input, 1 bit: `in_data` holds a word to send.
- `in_ready` output, 1 bit: the block can accept a word (IDLE only).
- `in_data` input, DATA_W bits: payload, sampled only on handshake.
- `serout` output, 1 bit: serial bit stream, registered.
- `frame` output, 1 bit: high while `serout` carries sync or data bits.
- `done` output, 1 bit: one-cycle pulse in the first GAP cycle.
- `ps` output, 2 bits: present state (debug).
- `ns` output, 2 bits: next state (combinational, debug).

## Operation
- States:
  - IDLE=2'b00: waiting for a word.
  - SYNC=2'b01: sending the sync pattern.
  - DATA=2'b10: sending the payload.
  - GAP=2'b11: sending idle zeros.
- Transitions:
  - IDLE→SYNC on `in_valid && in_ready`.
  - SYNC→DATA after SYNC_W bits.
  - DATA→GAP after DATA_W bits.
  - GAP→IDLE after GAP_CYC cycles.
- `in_ready` = (ps==IDLE), registered-state decode. `in_valid` outside IDLE is ignored; no word is queued.
- On handshake, load `{SYNC_PAT, in_data}` (SYNC_W+DATA_W bits) into the shift register and clear the bit counter. Each cycle of SYNC/DATA presents the shift-register MSB on `serout` and shifts left by one.
- The bit counter is $clog2(max(SYNC_W,DATA_W,GAP_CYC))+1 bits wide. It is reused per state and cleared on every state change.
- `serout` is 0 in IDLE and GAP. `frame` is 1 exactly in SYNC and DATA.
- Reset values (rst=0 at a rising edge), effective after that edge:
  - ps=IDLE, `serout`=0, `frame`=0, `done`=0.
  - Shift register and counter cleared.
  - `in_ready`=1 once rst returns high.
- Reset mid-frame: the frame is abandoned with no `done`. The next handshake starts a fresh frame.
- Reset asserted together with `in_valid`: reset wins and the word is not accepted.

## Timing
- Handshake at edge E0 gives the following cycle layout:
  - Cycles 1..SYNC_W: sync bits.
  - Cycles SYNC_W+1..SYNC_W+DATA_W: data bits.
  - Next GAP_CYC cycles: zeros.
  - Then IDLE.
- Each cycle n here is the clock period after edge En.
- Latency from handshake to the first `serout` bit: 1 cycle.
- Frame period with `in_valid` held high: SYNC_W+DATA_W+GAP_CYC+1 cycles. That is GAP_CYC+1 zero cycles between frames, including the IDLE cycle.
- `done` is high only in cycle SYNC_W+DATA_W+1.
- `ns` changes combinationally with `in_valid` in IDLE only. In all other states it depends only on state and counter.

## Structure
- Shared package `seq_det_pkg`:
  - State encoding localparams `ST_IDLE`, `ST_SYNC`, `ST_DATA`, `ST_GAP`.
  - Default `SYNC_PAT` and `SYNC_W`, shared with the detectors so both ends agree.
- One sub-module, `piso_shreg`: parallel-in/serial-out shift register, width SYNC_W+DATA_W, with `load` and `shift` enables and MSB output. The FSM, counter, `done` and `frame` logic stay in the top.

## Test plan
- Reset then one word (defaults), 8'hA5 handshaken at E0:
  - Cycles 1–12 `serout` = 1,0,1,1,1,0,1,0,0,1,0,1.
  - `frame`=1 in cycles 1–12.
  - Cycles 13–14 `serout`=0, `done`=1 in cycle 13 only.
  - `in_ready`=1 from cycle 15.
- Back-to-back 8'hFF then 8'h00 with `in_valid` held high:
  - Second handshake at E15.
  - Second sync starts in cycle 16.
  - Exactly 3 zero cycles between frames.
  - `ps` sequence 00→01→10→11→00.
- `in_valid` pulsed during DATA with 8'h3C while sending 8'h81: the 8'h3C is ignored, the output carries 8'h81 only, and `in_ready` stays 0 until IDLE.
- `rst`=0 for one edge during cycle 7 of a frame:
  - Next cycle `serout`=0, `frame`=0, ps=IDLE.
  - No `done` pulse.
  - A new word 8'h5A then transmits correctly from its sync.
- Parameter sweep DATA_W=1, SYNC_W=1, GAP_CYC=1 with SYNC_PAT=1'b1 and data 1: `serout` = 1,1,0, `done` in cycle 3, period 4 cycles.
- Loopback into the overlapping detector with 100 random words: detector hits align to every sync pattern, plus any pattern instances in the payload matching a software model.
